// File: rtl/reduce_sum_unit.sv
`default_nettype none
// ============================================================================
//  Module   : reduce_sum_unit
//  Summary  : Batched sum reduction. Incoming 32-bit elements are spread
//             round-robin across PAR lane accumulators. When a batch of
//             BUFFER_DEPTH elements completes, the lane snapshot enters a
//             pipelined adder tree and the total emerges with a one-cycle
//             strobe, while the next batch is already accumulating.
//  Revision : 1.0  initial release
// ============================================================================
module reduce_sum_unit #(
  parameter int PAR          = 4,
  parameter int BUFFER_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic        out_valid
);

  // Adder-tree depth, lane pointer width and batch counter width.
  localparam int C_STAGES = (PAR > 1) ? $clog2(PAR) : 0;
  localparam int C_PW     = (PAR > 1) ? $clog2(PAR) : 1;
  localparam int C_CW     = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  // Tree stored heap-style: node 0 is the root, children of n are 2n+1 and
  // 2n+2, leaves occupy PAR-1 .. 2*PAR-2.
  localparam int C_NODES  = 2 * PAR - 1;

  localparam logic [C_CW-1:0] C_LAST_CNT  = C_CW'(BUFFER_DEPTH - 1);
  localparam logic [C_PW-1:0] C_LAST_LANE = C_PW'(PAR - 1);

  logic [31:0]     lane_q [PAR];
  logic [31:0]     lane_d [PAR];
  logic [C_CW-1:0] cnt_q;
  logic [C_PW-1:0] ptr_q;

  logic [31:0]     node_q [C_NODES];
  logic [C_STAGES:0] vld_q;

  logic [31:0]     out_data_q;
  logic            out_valid_q;

  logic            batch_done;

  // The accept that brings the counter to its final slot closes the batch.
  assign batch_done = in_valid && (cnt_q == C_LAST_CNT);

  // Lane values after adding the current element to the selected lane.
  always_comb begin
    for (int p = 0; p < PAR; p++) begin
      lane_d[p] = lane_q[p];
      if (in_valid && (ptr_q == C_PW'(p))) begin
        lane_d[p] = lane_q[p] + in_data;
      end
    end
  end

  // Lane accumulators, batch counter and round-robin lane pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PAR; p++) lane_q[p] <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (in_valid) begin
      if (batch_done) begin
        // Snapshot is taken by the tree from lane_d on this same edge.
        for (int p = 0; p < PAR; p++) lane_q[p] <= '0;
        cnt_q <= '0;
        ptr_q <= '0;
      end else begin
        for (int p = 0; p < PAR; p++) lane_q[p] <= lane_d[p];
        cnt_q <= cnt_q + 1'b1;
        ptr_q <= (ptr_q == C_LAST_LANE) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  // Adder tree: leaves capture the snapshot, every internal node sums its
  // children each cycle, so data moves one level per clock; vld_q tracks
  // which level currently holds a real batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < C_NODES; n++) node_q[n] <= '0;
      vld_q <= '0;
    end else begin
      if (batch_done) begin
        for (int p = 0; p < PAR; p++) node_q[PAR-1+p] <= lane_d[p];
      end
      for (int n = 0; n < PAR - 1; n++) begin
        node_q[n] <= node_q[2*n+1] + node_q[2*n+2];
      end
      vld_q[0] <= batch_done;
      for (int k = 1; k <= C_STAGES; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // Output register: load the root total when its valid bit arrives, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_q[C_STAGES];
      if (vld_q[C_STAGES]) out_data_q <= node_q[0];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_sum_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reduce_sum_unit
//  Summary  : Self-checking bench for reduce_sum_unit (PAR=4, depth 1024).
//             Reference model: a batch total is the plain 32-bit sum of the
//             accepted elements, delivered 3 cycles after the last accept.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reduce_sum_unit;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  int hold_fail_prints = 0;

  // model state
  logic [31:0] psum = '0;
  int          pcnt = 0;
  logic [31:0] model_out = '0;
  ev_t exp_q[$];
  ev_t sched_q[$];
  ev_t got_q[$];

  reduce_sum_unit #(.PAR(4), .BUFFER_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Record strobes and check the held output value against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) got_q.push_back('{due: cyc, data: out_data});
      n_total++;
      if (out_data !== model_out) begin
        if (hold_fail_prints < 10)
          $display("FAIL out_data_hold cyc=%0d: got 0x%08h expected 0x%08h", cyc, out_data, model_out);
        hold_fail_prints++;
      end else begin
        n_pass++;
      end
    end
  end

  // One clock of stimulus plus the reference-model update for that edge.
  task automatic step(input logic r, input logic v, input logic [31:0] d);
    ev_t e;
    rst = r; in_valid = v; in_data = d;
    @(posedge clk);
    cyc++;
    if (r) begin
      psum = '0; pcnt = 0; model_out = '0;
      sched_q.delete();
      while (exp_q.size() > 0) begin
        e = exp_q[exp_q.size()-1];
        if (e.due >= cyc) void'(exp_q.pop_back());
        else break;
      end
    end else begin
      if (sched_q.size() > 0 && sched_q[0].due == cyc) begin
        model_out = sched_q[0].data;
        void'(sched_q.pop_front());
      end
      if (v) begin
        psum = psum + d;
        pcnt++;
        if (pcnt == DEPTH) begin
          e = '{due: cyc + LATENCY, data: psum};
          exp_q.push_back(e);
          sched_q.push_back(e);
          psum = '0; pcnt = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_total++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data: got 0x%08h expected 0x00000000", out_data);
    else n_pass++;
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_ramp(input int mult, input logic [31:0] spec_sum);
    ev_t g, e;
    int n;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'((mult * i) % 256));
    idle(6);
    n_total++;
    if (got_q.size() !== exp_q.size()) $display("FAIL ramp%0d_pulse_count: got %0d expected %0d", mult, got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (g.due !== e.due) $display("FAIL ramp%0d_pulse_cycle: got %0d expected %0d", mult, g.due, e.due);
      else n_pass++;
      n_total++;
      if (g.data !== spec_sum) $display("FAIL ramp%0d_sum: got 0x%08h expected 0x%08h", mult, g.data, spec_sum);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    ev_t g, e;
    int n;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'hFFFF_FFFF);
    idle(5);
    n_total++;
    if (got_q.size() !== exp_q.size()) $display("FAIL wrap_pulse_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (g.due !== e.due || g.data !== 32'hFFFF_FC00)
        $display("FAIL wrap_result: got cyc %0d 0x%08h expected cyc %0d 0xfffffc00", g.due, g.data, e.due);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_gaps();
    ev_t g, e;
    int n, acc;
    acc = 0;
    while (acc < DEPTH) begin
      if ($urandom_range(0, 2) == 0) begin
        step(1'b0, 1'b0, $urandom);
      end else begin
        step(1'b0, 1'b1, 32'd1);
        acc++;
      end
    end
    idle(5);
    n_total++;
    if (got_q.size() !== exp_q.size()) $display("FAIL gaps_pulse_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (g.due !== e.due || g.data !== 32'd1024)
        $display("FAIL gaps_result: got cyc %0d 0x%08h expected cyc %0d 0x00000400", g.due, g.data, e.due);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t g, e;
    int n;
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 1'b1, $urandom);
    idle(5);
    n_total++;
    if (got_q.size() !== 2) $display("FAIL b2b_pulse_count: got %0d expected 2", got_q.size());
    else n_pass++;
    if (got_q.size() == 2) begin
      n_total++;
      if (got_q[1].due - got_q[0].due !== DEPTH)
        $display("FAIL b2b_spacing: got %0d expected %0d", got_q[1].due - got_q[0].due, DEPTH);
      else n_pass++;
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (g.due !== e.due || g.data !== e.data)
        $display("FAIL b2b_result%0d: got cyc %0d 0x%08h expected cyc %0d 0x%08h", i, g.due, g.data, e.due, e.data);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t g, e;
    int n;
    // partial batch discarded
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, $urandom);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, $urandom);
    idle(3);
    // full batch whose result is still in the tree when reset hits
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, $urandom);
    step(1'b1, 1'b0, '0);
    idle(6);
    n_total++;
    if (got_q.size() !== 0) $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", got_q.size());
    else n_pass++;
    n_total++;
    if (out_data !== 32'h0) $display("FAIL reset_mid_out_data: got 0x%08h expected 0x00000000", out_data);
    else n_pass++;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'd1);
    idle(5);
    n_total++;
    if (got_q.size() !== exp_q.size()) $display("FAIL reset_mid_pulse_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (g.due !== e.due || g.data !== 32'd1024)
        $display("FAIL reset_mid_result: got cyc %0d 0x%08h expected cyc %0d 0x00000400", g.due, g.data, e.due);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_ramp(1, 32'h0001_FE00);
    test_ramp(2, 32'h0001_FC00);
    test_wrap();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reduce_sum_unit.md
REDUCE_SUM_UNIT -- requirements
Module: reduce_sum

Interface
REQ-001 Parameter PAR, default 4: number of parallel lane accumulators; SHALL be a power of two in {1,2,4,8,16}.
REQ-002 Parameter BUFFER_DEPTH, default 1024: number of accepted inputs per reduction batch; SHALL be in 1..65536.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  32  unsigned input element.
REQ-006 in_valid  input  1  in_data is accepted on any rising edge where in_valid=1 and rst=0; no backpressure.
REQ-007 out_data  output  32  registered batch sum.
REQ-008 out_valid  output  1  registered one-cycle strobe marking a new out_data.

Function
REQ-009 Design SHALL keep PAR 32-bit lane accumulators, a batch element counter (0..BUFFER_DEPTH-1) and a lane pointer (0..PAR-1).
REQ-010 Each accepted element SHALL be added to the lane selected by the lane pointer; the pointer then advances modulo PAR and the counter increments.
REQ-011 All additions SHALL be unsigned modulo 2^32; carries discarded, no saturation.
REQ-012 Cycles with in_valid=0 SHALL leave all accumulators, counter and pointer unchanged; gaps of any length are legal mid-batch.
REQ-013 On the edge E that accepts the BUFFER_DEPTH-th element, the design SHALL load a snapshot of all lanes (including that element) into the reduction pipeline and, on the same edge, clear all lanes, counter and lane pointer to 0.
REQ-014 Reduction SHALL be a pipelined pairwise adder tree of log2(PAR) registered stages, one stage per cycle, wrapping modulo 2^32.
REQ-015 out_data SHALL be loaded with the total and out_valid asserted on edge E+log2(PAR)+1 (PAR=4: E+3; PAR=1: E+1).
REQ-016 out_valid SHALL be high for exactly one cycle per batch; out_data SHALL hold its value until the next batch result.
REQ-017 Inputs for the next batch SHALL be accepted on edge E+1 onward with no bubble, while the previous batch is still in the reduction pipeline.
REQ-018 The pipeline SHALL carry a valid bit per stage so results from overlapping batches emerge in order, each with its own one-cycle out_valid strobe.
REQ-019 Throughput SHALL be one input per cycle sustained; no input is ever dropped while rst=0.

Reset
REQ-020 While rst=1 on a clock edge: all lanes, counter, lane pointer, pipeline data and valid bits, out_data and out_valid SHALL become 0; in_valid is ignored.
REQ-021 Reset mid-batch or mid-reduction SHALL discard the partial batch and any in-flight result; no out_valid is produced for it.
REQ-022 The first element accepted after reset deassertion SHALL start a new batch in lane 0.

Verification
REQ-023 PAR=4, BUFFER_DEPTH=1024, inputs i%256 for i=0..1023 back-to-back -> single out_valid pulse 3 cycles after last accept, out_data=0x0001FE00.
REQ-024 Following batch (2*i)%256 for i=0..1023 -> out_data=0x0001FC00, one pulse; prior out_data held between pulses.
REQ-025 1024 inputs of 0xFFFFFFFF -> out_data=0xFFFFFC00 (wrap-around).
REQ-026 Batch of all 1s with random in_valid gaps -> out_data=1024, strobe 3 cycles after the 1024th accept; no early out_valid.
REQ-027 Two batches back-to-back, no idle cycle between -> two in-order pulses exactly 1024 cycles apart with correct sums.
REQ-028 rst asserted after 500 inputs, then 1024 inputs of value 1 -> out_valid=0 until the new batch completes, out_data=1024 (no stale contribution).
